// File: rtl/amdemod_pkg.sv
// ---------------------------------------------------------------------------
// amdemod_pkg
// Shared constants and helpers for the AM demodulator datapath stages.
//   IN_W / OUT_W : default sample widths of the filter output / decimated out
//   sat_wide_t   : wide signed carrier used for saturation
//   sat_signed() : clamp a wide signed value into a w-bit signed range
// ---------------------------------------------------------------------------
package amdemod_pkg;

    localparam int IN_W  = 18;
    localparam int OUT_W = 8;

    // Wide enough for any intermediate the demodulator stages saturate.
    localparam int SAT_W = 48;

    typedef logic signed [SAT_W-1:0] sat_wide_t;

    // Returns v clamped to [-2^(w-1), 2^(w-1)-1]; callers detect clamping
    // by comparing the result against the input.
    function automatic sat_wide_t sat_signed(input sat_wide_t v, input int w);
        sat_wide_t hi;
        sat_wide_t lo;
        hi = (sat_wide_t'(1) <<< (w - 1)) - sat_wide_t'(1);
        lo = -hi - sat_wide_t'(1);
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_decim_out_if.sv
// ---------------------------------------------------------------------------
// fir_decim_out_if
// Valid/ready output stream of the decimator.
//   out_data  : decimated signed sample (FIFO head)
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts out_data when out_valid is high
// master = producer (fir_decim_out), slave = consumer.
// ---------------------------------------------------------------------------
interface fir_decim_out_if #(
    parameter int OUT_W = amdemod_pkg::OUT_W
);
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fir_decim_out_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with extra-MSB wrap pointers.
//   clk, rst : clock, async active-high reset (pointers only)
//   push/din : write request and data; ignored when full unless popping
//   pop      : read request; ignored when empty
//   dout     : head entry, combinational from the read pointer; 0 when empty
//   full     : DEPTH entries held
//   empty    : no entries held
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop && !w_empty;
    // A simultaneous pop frees the slot being written, so full does not block.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible behind the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

    assign dout  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: rtl/fir_decim_out.sv
// ---------------------------------------------------------------------------
// fir_decim_out
// Integrate-and-dump decimator behind the FIR filter. Every DECIM valid
// samples are summed, rounded half-up by 2^S (S = log2(DECIM)+GAIN_SHIFT),
// saturated to OUT_W bits, registered, then queued in an output FIFO.
//   clk, rst  : clock, async active-high reset
//   y/y_valid : filtered signed sample and its one-cycle strobe
//   sync      : restart the decimation frame (partial frame discarded)
//   out_if    : valid/ready output stream (master side)
//   sat_flag  : sticky, a result was clamped
//   ovf_flag  : sticky, a result was dropped on a full FIFO
// ---------------------------------------------------------------------------
module fir_decim_out #(
    parameter int IN_W       = amdemod_pkg::IN_W,
    parameter int OUT_W      = amdemod_pkg::OUT_W,
    parameter int DECIM      = 4,
    parameter int GAIN_SHIFT = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] y,
    input  logic                   y_valid,
    input  logic                   sync,
    fir_decim_out_if.master        out_if,
    output logic                   sat_flag,
    output logic                   ovf_flag
);
    import amdemod_pkg::sat_wide_t;
    import amdemod_pkg::sat_signed;

    localparam int LOG_D = $clog2(DECIM);
    localparam int ACC_W = IN_W + LOG_D;
    localparam int S     = LOG_D + GAIN_SHIFT;
    // One guard bit so adding the rounding constant to a full-scale sum
    // cannot wrap; also wide enough to hold 2^(S-1) itself.
    localparam int RND_W = ((ACC_W > S) ? ACC_W : S) + 1;

    localparam logic [LOG_D-1:0]        LAST_PHASE = LOG_D'(DECIM - 1);
    localparam logic signed [RND_W-1:0] HALF       = RND_W'(1) << (S - 1);

    logic signed [ACC_W-1:0] r_acc;
    logic [LOG_D-1:0]        r_phase;
    logic                    r_rnd_valid;
    logic signed [OUT_W-1:0] r_rnd_data;
    logic                    r_sat;
    logic                    r_ovf;

    logic signed [ACC_W-1:0] w_acc_base;
    logic [LOG_D-1:0]        w_phase_base;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_frame_end;
    logic signed [RND_W-1:0] w_rnd_full;
    sat_wide_t               w_rnd_wide;
    sat_wide_t               w_sat_wide;
    logic                    w_clamped;

    logic [OUT_W-1:0]        w_fifo_dout;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_pop;

    // sync with y_valid makes the current sample the first of a new frame.
    assign w_acc_base   = sync ? '0 : r_acc;
    assign w_phase_base = sync ? '0 : r_phase;
    assign w_sum        = w_acc_base + ACC_W'(y);
    assign w_frame_end  = y_valid && (w_phase_base == LAST_PHASE);

    // Arithmetic shift floors, so adding half first yields round-half-up.
    assign w_rnd_full = (RND_W'(w_sum) + HALF) >>> S;
    assign w_rnd_wide = sat_wide_t'(w_rnd_full);
    assign w_sat_wide = sat_signed(w_rnd_wide, OUT_W);
    assign w_clamped  = (w_sat_wide != w_rnd_wide);

    assign w_pop = !w_fifo_empty && out_if.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_phase     <= '0;
            r_rnd_valid <= 1'b0;
            r_rnd_data  <= '0;
            r_sat       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_rnd_valid <= 1'b0;
            if (y_valid) begin
                if (w_frame_end) begin
                    r_acc       <= '0;
                    r_phase     <= '0;
                    r_rnd_valid <= 1'b1;
                    r_rnd_data  <= w_sat_wide[OUT_W-1:0];
                    if (w_clamped) begin
                        r_sat <= 1'b1;
                    end
                end else begin
                    r_acc   <= w_sum;
                    r_phase <= w_phase_base + 1'b1;
                end
            end else if (sync) begin
                r_acc   <= '0;
                r_phase <= '0;
            end
            // The FIFO silently refuses this write; record the loss here.
            if (r_rnd_valid && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_rnd_valid),
        .din   (r_rnd_data),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign out_if.out_data  = w_fifo_dout;
    assign out_if.out_valid = !w_fifo_empty;
    assign sat_flag         = r_sat;
    assign ovf_flag         = r_ovf;

endmodule

// File: tb/tb_fir_decim_out.sv
module tb_fir_decim_out;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic signed [17:0]  y = '0;
    logic                y_valid = 1'b0;
    logic                sync = 1'b0;
    logic                sat_flag;
    logic                ovf_flag;

    fir_decim_out_if #(.OUT_W(8)) u_if ();

    fir_decim_out #(
        .IN_W       (18),
        .OUT_W      (8),
        .DECIM      (4),
        .GAIN_SHIFT (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .y_valid  (y_valid),
        .sync     (sync),
        .out_if   (u_if.master),
        .sat_flag (sat_flag),
        .ovf_flag (ovf_flag)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Frame average: floor((sum + 2048) / 4096), clamped to int8.
    int frame_q[$];
    int exp_q[$];
    bit model_sat;
    bit mon_en = 1'b0;

    function automatic int ref_result(input longint sum, output bit clamped);
        longint n;
        longint q;
        n = sum + 2048;
        q = n / 4096;
        if ((n % 4096) != 0 && n < 0) q = q - 1;
        clamped = 1'b0;
        if (q > 127) begin q = 127; clamped = 1'b1; end
        if (q < -128) begin q = -128; clamped = 1'b1; end
        return int'(q);
    endfunction

    task automatic model_step(input bit v, input int val, input bit s);
        longint sum;
        bit c;
        if (s) frame_q.delete();
        if (v) begin
            frame_q.push_back(val);
            if (frame_q.size() == 4) begin
                sum = 0;
                foreach (frame_q[k]) sum += frame_q[k];
                exp_q.push_back(ref_result(sum, c));
                if (c) model_sat = 1'b1;
                frame_q.delete();
            end
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic drive_cycle(input bit v, input int val, input bit s);
        y       = 18'(val);
        y_valid = v;
        sync    = s;
        model_step(v, val, s);
        @(posedge clk);
        #1;
        y_valid = 1'b0;
        sync    = 1'b0;
    endtask

    task automatic push_sample(input int val, input bit s = 1'b0);
        drive_cycle(1'b1, val, s);
    endtask

    task automatic do_reset();
        y = '0; y_valid = 1'b0; sync = 1'b0;
        u_if.out_ready = 1'b1;
        frame_q.delete();
        exp_q.delete();
        model_sat = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid at a negedge; ends at posedge+1.
    task automatic wait_out(input string nm, input int budget, output int d);
        bit got;
        got = 1'b0;
        d = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (u_if.out_valid) begin
                got = 1'b1;
                d = int'(u_if.out_data);
            end
        end
        if (!got) chk({nm, "_valid"}, int'(u_if.out_valid), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic count_outputs(input int cycles, output int cnt, output int last);
        cnt = 0;
        last = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (u_if.out_valid && u_if.out_ready) begin
                cnt++;
                last = int'(u_if.out_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Random-phase scoreboard: every accepted output must match the model.
    always @(negedge clk) begin
        if (mon_en && u_if.out_valid && u_if.out_ready) begin
            if (exp_q.size() == 0) chk("rand_unexpected_out", int'(u_if.out_valid), 0);
            else chk("rand_data", int'(u_if.out_data), exp_q.pop_front());
        end
    end

    typedef struct {
        int s0, s1, s2, s3;
        int exp_out;
        bit exp_sat;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, cnt, last;
        int v;

        vecs[0] = '{1024, 1024, 1024, 1024, 1, 1'b0};
        vecs[1] = '{512, 512, 512, 512, 1, 1'b0};
        vecs[2] = '{512, 512, 512, 511, 0, 1'b0};
        vecs[3] = '{-512, -512, -512, -512, 0, 1'b0};
        vecs[4] = '{-512, -512, -512, -513, -1, 1'b0};
        vecs[5] = '{131071, 131071, 131071, 131071, 127, 1'b1};
        vecs[6] = '{-131072, -131072, -131072, -131072, -128, 1'b0};

        // Reset state
        u_if.out_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(u_if.out_valid), 0);
        chk("rst_out_data", int'(u_if.out_data), 0);
        chk("rst_sat", int'(sat_flag), 0);
        chk("rst_ovf", int'(ovf_flag), 0);

        // Table vectors, each from a fresh reset
        for (int i = 0; i < 7; i++) begin
            do_reset();
            push_sample(vecs[i].s0);
            push_sample(vecs[i].s1);
            push_sample(vecs[i].s2);
            push_sample(vecs[i].s3);
            wait_out($sformatf("vec%0d", i), 10, d);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_out);
            chk($sformatf("vec%0d_sat", i), int'(sat_flag), int'(vecs[i].exp_sat));
        end

        // Sticky saturation: positive clamp then an unclamped -128 frame
        do_reset();
        for (int i = 0; i < 4; i++) push_sample(131071);
        for (int i = 0; i < 4; i++) push_sample(-131072);
        repeat (4) @(posedge clk);
        #1;
        chk("sat_sticky", int'(sat_flag), 1);

        // Latency: frame end in cycle t -> out_valid at t+2
        do_reset();
        for (int i = 0; i < 4; i++) push_sample(1024);
        @(negedge clk);
        chk("lat_t1_valid", int'(u_if.out_valid), 0);
        @(negedge clk);
        chk("lat_t2_valid", int'(u_if.out_valid), 1);
        chk("lat_t2_data", int'(u_if.out_data), 1);
        @(posedge clk);
        #1;

        // Overflow: five frames 1..5 with consumer stalled
        do_reset();
        u_if.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++)
            for (int i = 0; i < 4; i++) push_sample(k * 1024);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_after4", int'(ovf_flag), 0);
        for (int i = 0; i < 4; i++) push_sample(5 * 1024);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_after5", int'(ovf_flag), 1);
        @(negedge clk);
        chk("ovf_head", int'(u_if.out_data), 1);
        @(negedge clk);
        chk("ovf_head_stable", int'(u_if.out_data), 1);
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("ovf_drain%0d_valid", i), int'(u_if.out_valid), 1);
            chk($sformatf("ovf_drain%0d_data", i), int'(u_if.out_data), i + 1);
        end
        @(negedge clk);
        chk("ovf_drained_valid", int'(u_if.out_valid), 0);
        @(posedge clk);
        #1;

        // Sync restarts the frame; the two leading samples are discarded
        do_reset();
        push_sample(100000);
        push_sample(100000);
        push_sample(1024, 1'b1);
        for (int i = 0; i < 3; i++) push_sample(1024);
        count_outputs(10, cnt, last);
        chk("sync_count", cnt, 1);
        chk("sync_data", last, 1);

        // Async reset mid-frame with two FIFO entries
        do_reset();
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_sample(1024);
        repeat (3) @(posedge clk);
        #1;
        chk("arst_pre_valid", int'(u_if.out_valid), 1);
        push_sample(1024);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid_now", int'(u_if.out_valid), 0);
        chk("arst_data_now", int'(u_if.out_data), 0);
        #1 rst = 1'b0;
        u_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) push_sample(1024);
        count_outputs(6, cnt, last);
        chk("arst_no_early_out", cnt, 0);
        push_sample(1024);
        wait_out("arst_fresh", 10, d);
        chk("arst_fresh_data", d, 1);

        // Randomized run against the model
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 8191)) - 4096;
            else v = int'($urandom_range(0, 262143)) - 131072;
            drive_cycle(($urandom_range(0, 3) != 0), v, ($urandom_range(0, 15) == 0));
        end
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("rand_drain", exp_q.size(), 0);
        chk("rand_sat", int'(sat_flag), int'(model_sat));
        chk("rand_ovf", int'(ovf_flag), 0);
        mon_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output stage directly downstream of the FIR filter in the AM demodulator chain. It takes the filter's 18-bit signed sample stream and decimates it by an integrate-and-dump of `DECIM` samples. Each dumped sum is rounded and scaled to an 8-bit signed result, saturated, and buffered in a small FIFO drained through a valid/ready handshake. Sticky flags report saturation and FIFO overflow; the upstream filter cannot be stalled.

## Interface
Parameters:
- `IN_W`, 18, input sample width (signed).
- `OUT_W`, 8, output sample width (signed).
- `DECIM`, 4, decimation factor; power of two, 2..16.
- `GAIN_SHIFT`, 10, extra right shift after averaging.
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  reset, asynchronous, active-high.
- `y`  in  IN_W  filtered sample, signed.
- `y_valid`  in  1  one-cycle strobe per new `y`.
- `sync`  in  1  synchronous restart of the decimation frame.
- `out_data`  out  OUT_W  decimated sample, signed.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid` is high.
- `sat_flag`  out  1  sticky, set when any result saturated.
- `ovf_flag`  out  1  sticky, set when a result was dropped on a full FIFO.

## Operation
- Reset values:
  - outputs: `out_data`=0, `out_valid`=0, `sat_flag`=0, `ovf_flag`=0.
  - internal: accumulator=0, phase=0, FIFO empty.
- Accumulator width: IN_W+log2(DECIM), signed.
- On each `y_valid`:
  - phase<DECIM-1: acc += y, phase++.
  - phase=DECIM-1: sum = acc + y goes to the round stage; acc=0, phase=0.
- Round stage, with S = log2(DECIM)+GAIN_SHIFT:
  - r = (sum + 2^(S-1)) >>> S. This is round-half-up; arithmetic shift floors negatives.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If clamped, set `sat_flag`.
- The rounded result is registered, then written to the FIFO on the next cycle.
- If the FIFO is full on that write, the result is dropped and `ovf_flag` is set. A pop in the same cycle counts as not full: with one pop and one write, the write succeeds.
- `sync` clears acc and phase.
  - `sync` together with `y_valid`: that sample becomes sample 0 of the new frame.
  - The partial frame is discarded.
  - A result already in the round stage still completes.
- Flags clear only on `rst`.
- `y_valid` without `sync` while `out_ready` is low: accumulation continues. Only the FIFO stage drops results.

## Timing
- Latency: frame-completing `y_valid` in cycle t → result registered at t+1 → `out_valid` high and `out_data` valid at t+2, when the FIFO was empty.
- Handshake:
  - Pop occurs on a rising edge with `out_valid`&&`out_ready`.
  - `out_data` shows the FIFO head combinationally from the read pointer register; it is stable while `out_valid`&&!`out_ready`.
- Throughput: `y_valid` may assert every cycle. Back-to-back frames are sustained with `out_ready` held high.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits, wrap-around naturally; full means the MSBs differ and the low bits are equal.
- `rst` asserted mid-frame or mid-handshake:
  - takes effect immediately and asynchronously;
  - FIFO contents are discarded;
  - `out_valid` drops without waiting for a clock.

## Structure
- Shared package `amdemod_pkg`: sample-width constants (IN_W=18, OUT_W=8) and a signed saturate function reused by other stages.
- One sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty).
- Accumulator, round and saturate logic stays in `fir_decim_out`.

## Test plan
- Defaults (DECIM=4, S=12); ready high; y=1024 on every `y_valid` → `out_data`=1 per 4 inputs; `sat_flag`=0.
- Rounding boundaries:
  - frame sums 2048 → 1; 2047 → 0.
  - frame sums -2048 → 0; -2049 → -1.
- Saturation: four samples of 131071 → 127 with `sat_flag`=1. Four samples of -131072 → -128 with `sat_flag` still only from the first case; verify after a fresh reset that this alone leaves it at 0.
- Overflow with `out_ready`=0: five full frames of value 1..5 → FIFO holds 4 entries and `ovf_flag`=1. Raising `out_ready` → outputs 1,2,3,4 in order, then `out_valid`=0.
- Sync: two samples, then `sync` together with `y_valid`, then three more (4 total in the new frame) → exactly one output, computed from the new frame only.
- Async reset mid-frame with 2 FIFO entries → `out_valid`=0 immediately. The next result needs 4 fresh `y_valid`s.
